// File: rtl/rs_pkg.sv
// Shared types and default sizes for the unified reservation station.
// Optional counters are enabled with the RS_PERF_CNT_EN macro.
package rs_pkg;

    localparam int RS_SS        = 2;
    localparam int RS_ISSUE     = 2;
    localparam int RS_CDB_W     = 2;
    localparam int RS_DEPTH     = 16;
    localparam int RS_PREG_W    = 6;
    localparam int RS_ROB_W     = 5;
    localparam int RS_PAYLOAD_W = 64;

    localparam int RS_IDX_W = $clog2(RS_DEPTH);
    localparam int RS_FU_W  = (RS_ISSUE > 1) ? $clog2(RS_ISSUE) : 1;

    typedef enum logic [RS_FU_W-1:0] {
        FU_ALU = RS_FU_W'(0),
        FU_MUL = RS_FU_W'(1)
    } fu_class_e;

    typedef struct packed {
        logic                    valid;
        logic [RS_PREG_W-1:0]    ps1;
        logic [RS_PREG_W-1:0]    ps2;
        logic                    rdy1;
        logic                    rdy2;
        logic [RS_FU_W-1:0]      fu;
        logic [RS_ROB_W-1:0]     rob;
        logic [RS_PAYLOAD_W-1:0] payload;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix: age_q[i][j]=1 means entry j is older than entry i.
// Produces a one-hot oldest grant per issue port from its request vector.
module rs_age_matrix
    import rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int SS    = RS_SS,
    parameter int ISSUE = RS_ISSUE,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SS-1:0]                  alloc_valid_i,
    input  logic [SS-1:0][IDX_W-1:0]       alloc_idx_i,
    input  logic [DEPTH-1:0]               occ_i,
    input  logic [ISSUE-1:0][DEPTH-1:0]    req_i,
    output logic [ISSUE-1:0][DEPTH-1:0]    gnt_o
);

    logic [DEPTH-1:0][DEPTH-1:0] age_q;
    logic [DEPTH-1:0][DEPTH-1:0] age_d;
    logic [DEPTH-1:0][DEPTH-1:0] lower;
    logic [DEPTH-1:0]            alloc_vec;

    // Decode allocations and which entries came from lower lanes of the group
    always_comb begin
        alloc_vec = '0;
        lower     = '0;
        for (int m = 0; m < SS; m++) begin
            if (alloc_valid_i[m]) begin
                alloc_vec[alloc_idx_i[m]] = 1'b1;
                for (int l = 0; l < SS; l++) begin
                    if (l < m && alloc_valid_i[l]) begin
                        lower[alloc_idx_i[m]][alloc_idx_i[l]] = 1'b1;
                    end
                end
            end
        end
    end

    // New entry is younger than all resident and lower-lane entries
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (alloc_vec[i]) begin
                    age_d[i][j] = occ_i[j] | lower[i][j];
                end else if (alloc_vec[j]) begin
                    age_d[i][j] = 1'b0;
                end
            end
        end
    end

    // Grant the requester with no older requester on the same port
    always_comb begin
        gnt_o = '0;
        for (int k = 0; k < ISSUE; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                gnt_o[k][i] = req_i[k][i] & ~(|(req_i[k] & age_q[i]));
            end
        end
    end

    // Matrix state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/rs_station_multi.sv
// Unified reservation station: multi-lane dispatch, CDB wakeup, oldest-first issue.
// Define RS_PERF_CNT_EN to build the issue / full-cycle performance counters.
module rs_station_multi
    import rs_pkg::*;
#(
    parameter int SS        = RS_SS,
    parameter int ISSUE     = RS_ISSUE,
    parameter int CDB_W     = RS_CDB_W,
    parameter int DEPTH     = RS_DEPTH,
    parameter int PREG_W    = RS_PREG_W,
    parameter int ROB_W     = RS_ROB_W,
    parameter int PAYLOAD_W = RS_PAYLOAD_W,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = IDX_W + 1,
    localparam int FU_W  = (ISSUE > 1) ? $clog2(ISSUE) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [SS-1:0]                   dispatch_valid,
    output logic                            dispatch_ready,
    input  logic [SS-1:0][PREG_W-1:0]       disp_ps1,
    input  logic [SS-1:0][PREG_W-1:0]       disp_ps2,
    input  logic [SS-1:0]                   disp_rdy1,
    input  logic [SS-1:0]                   disp_rdy2,
    input  logic [SS-1:0][FU_W-1:0]         disp_fu,
    input  logic [SS-1:0][ROB_W-1:0]        disp_rob,
    input  logic [SS-1:0][PAYLOAD_W-1:0]    disp_payload,
    input  logic [CDB_W-1:0]                cdb_valid,
    input  logic [CDB_W-1:0][PREG_W-1:0]    cdb_preg,
    output logic [ISSUE-1:0]                issue_valid,
    input  logic [ISSUE-1:0]                issue_ready,
    output logic [ISSUE-1:0][PREG_W-1:0]    issue_ps1,
    output logic [ISSUE-1:0][PREG_W-1:0]    issue_ps2,
    output logic [ISSUE-1:0][ROB_W-1:0]     issue_rob,
    output logic [ISSUE-1:0][PAYLOAD_W-1:0] issue_payload,
    output logic [CNT_W-1:0]                free_count,
    output logic [31:0]                     perf_issued,
    output logic [31:0]                     perf_full_cycles
);

    rs_entry_t [DEPTH-1:0] ent_q;
    rs_entry_t [DEPTH-1:0] ent_d;

    logic [DEPTH-1:0]            occ;
    logic [CNT_W-1:0]            free_cnt;
    logic                        accept;
    logic [SS-1:0]               alloc_v;
    logic [SS-1:0][IDX_W-1:0]    alloc_idx;
    logic [DEPTH-1:0]            taken;
    logic                        found;
    logic [ISSUE-1:0][DEPTH-1:0] req;
    logic [ISSUE-1:0][DEPTH-1:0] gnt;
    logic [ISSUE-1:0]            hs;
    logic [DEPTH-1:0]            issued;

    function automatic logic cdb_hit(
        input logic [CDB_W-1:0]             v,
        input logic [CDB_W-1:0][PREG_W-1:0] p,
        input logic [PREG_W-1:0]            tag
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < CDB_W; w++) begin
            hit = hit | (v[w] & (p[w] == tag));
        end
        return hit;
    endfunction

    // Occupancy and free count from registered state only
    always_comb begin
        occ      = '0;
        free_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i]   = ent_q[i].valid;
            free_cnt = free_cnt + CNT_W'(!ent_q[i].valid);
        end
    end

    assign free_count     = free_cnt;
    assign dispatch_ready = (free_cnt >= CNT_W'(SS));
    assign accept         = dispatch_ready & ~flush & (|dispatch_valid);
    assign alloc_v        = dispatch_valid & {SS{accept}};

    // Valid lanes take the lowest free entries in lane order
    always_comb begin
        taken     = occ;
        alloc_idx = '0;
        found     = 1'b0;
        for (int l = 0; l < SS; l++) begin
            found = 1'b0;
            if (dispatch_valid[l]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!found && !taken[i]) begin
                        alloc_idx[l] = IDX_W'(i);
                        taken[i]     = 1'b1;
                        found        = 1'b1;
                    end
                end
            end
        end
    end

    // Per-port request: valid, both operands ready, matching FU class
    always_comb begin
        req = '0;
        for (int k = 0; k < ISSUE; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                req[k][i] = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2
                          & (ent_q[i].fu == FU_W'(k));
            end
        end
    end

    rs_age_matrix #(
        .DEPTH (DEPTH),
        .SS    (SS),
        .ISSUE (ISSUE)
    ) u_age (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_valid_i (alloc_v),
        .alloc_idx_i   (alloc_idx),
        .occ_i         (occ),
        .req_i         (req),
        .gnt_o         (gnt)
    );

    // Present granted entries and derive handshakes
    always_comb begin
        issue_valid   = '0;
        issue_ps1     = '0;
        issue_ps2     = '0;
        issue_rob     = '0;
        issue_payload = '0;
        hs            = '0;
        issued        = '0;
        for (int k = 0; k < ISSUE; k++) begin
            issue_valid[k] = (|gnt[k]) & ~flush;
            for (int i = 0; i < DEPTH; i++) begin
                if (gnt[k][i]) begin
                    issue_ps1[k]     = ent_q[i].ps1;
                    issue_ps2[k]     = ent_q[i].ps2;
                    issue_rob[k]     = ent_q[i].rob;
                    issue_payload[k] = ent_q[i].payload;
                end
            end
            hs[k] = issue_valid[k] & issue_ready[k];
            for (int i = 0; i < DEPTH; i++) begin
                issued[i] = issued[i] | (gnt[k][i] & hs[k]);
            end
        end
    end

    // Entry update: wakeup, issue release, allocation with bypass, flush
    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                if (cdb_hit(cdb_valid, cdb_preg, ent_q[i].ps1)) begin
                    ent_d[i].rdy1 = 1'b1;
                end
                if (cdb_hit(cdb_valid, cdb_preg, ent_q[i].ps2)) begin
                    ent_d[i].rdy2 = 1'b1;
                end
                if (issued[i]) begin
                    ent_d[i].valid = 1'b0;
                end
            end
        end
        for (int l = 0; l < SS; l++) begin
            if (alloc_v[l]) begin
                ent_d[alloc_idx[l]].valid   = 1'b1;
                ent_d[alloc_idx[l]].ps1     = disp_ps1[l];
                ent_d[alloc_idx[l]].ps2     = disp_ps2[l];
                ent_d[alloc_idx[l]].rdy1    = disp_rdy1[l]
                    | (disp_ps1[l] == '0)
                    | cdb_hit(cdb_valid, cdb_preg, disp_ps1[l]);
                ent_d[alloc_idx[l]].rdy2    = disp_rdy2[l]
                    | (disp_ps2[l] == '0)
                    | cdb_hit(cdb_valid, cdb_preg, disp_ps2[l]);
                ent_d[alloc_idx[l]].fu      = disp_fu[l];
                ent_d[alloc_idx[l]].rob     = disp_rob[l];
                ent_d[alloc_idx[l]].payload = disp_payload[l];
            end
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

`ifdef RS_PERF_CNT_EN
    logic [31:0] perf_iss_q;
    logic [31:0] perf_full_q;
    logic [31:0] hs_cnt;

    // Number of issue handshakes this cycle
    always_comb begin
        hs_cnt = '0;
        for (int k = 0; k < ISSUE; k++) begin
            hs_cnt = hs_cnt + 32'(hs[k]);
        end
    end

    // Free-running counters; flush leaves them alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_iss_q  <= '0;
            perf_full_q <= '0;
        end else begin
            perf_iss_q  <= perf_iss_q + hs_cnt;
            perf_full_q <= perf_full_q + 32'(!dispatch_ready);
        end
    end

    assign perf_issued      = perf_iss_q;
    assign perf_full_cycles = perf_full_q;
`else
    assign perf_issued      = '0;
    assign perf_full_cycles = '0;
`endif

endmodule

// File: tb/tb_rs_station_multi.sv
// Scoreboard bench for rs_station_multi.
// Expected issues are queued per port at stimulus time and checked on handshake.
module tb_rs_station_multi;
    import rs_pkg::*;

    localparam int SS = 2;
    localparam int ISSUE = 2;
    localparam int CDB_W = 2;
    localparam int PREG_W = 6;
    localparam int ROB_W = 5;
    localparam int PW = 64;

    logic                          clk;
    logic                          rst_n;
    logic                          flush;
    logic [SS-1:0]                 dispatch_valid;
    logic                          dispatch_ready;
    logic [SS-1:0][PREG_W-1:0]     disp_ps1;
    logic [SS-1:0][PREG_W-1:0]     disp_ps2;
    logic [SS-1:0]                 disp_rdy1;
    logic [SS-1:0]                 disp_rdy2;
    logic [SS-1:0][0:0]            disp_fu;
    logic [SS-1:0][ROB_W-1:0]      disp_rob;
    logic [SS-1:0][PW-1:0]         disp_payload;
    logic [CDB_W-1:0]              cdb_valid;
    logic [CDB_W-1:0][PREG_W-1:0]  cdb_preg;
    logic [ISSUE-1:0]              issue_valid;
    logic [ISSUE-1:0]              issue_ready;
    logic [ISSUE-1:0][PREG_W-1:0]  issue_ps1;
    logic [ISSUE-1:0][PREG_W-1:0]  issue_ps2;
    logic [ISSUE-1:0][ROB_W-1:0]   issue_rob;
    logic [ISSUE-1:0][PW-1:0]      issue_payload;
    logic [4:0]                    free_count;
    logic [31:0]                   perf_issued;
    logic [31:0]                   perf_full_cycles;

    typedef struct packed {
        logic [5:0]  ps1;
        logic [5:0]  ps2;
        logic [4:0]  rob;
        logic [63:0] pl;
    } exp_t;

    exp_t sbq[2][$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    rs_station_multi dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .dispatch_valid   (dispatch_valid),
        .dispatch_ready   (dispatch_ready),
        .disp_ps1         (disp_ps1),
        .disp_ps2         (disp_ps2),
        .disp_rdy1        (disp_rdy1),
        .disp_rdy2        (disp_rdy2),
        .disp_fu          (disp_fu),
        .disp_rob         (disp_rob),
        .disp_payload     (disp_payload),
        .cdb_valid        (cdb_valid),
        .cdb_preg         (cdb_preg),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_ps1        (issue_ps1),
        .issue_ps2        (issue_ps2),
        .issue_rob        (issue_rob),
        .issue_payload    (issue_payload),
        .free_count       (free_count),
        .perf_issued      (perf_issued),
        .perf_full_cycles (perf_full_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pl_of(input logic [4:0] rob);
        return {32'hC0DE_F00D, 27'd0, rob};
    endfunction

    // Handshakes are sampled on the falling edge and checked in order
    always @(negedge clk) begin
        for (int k = 0; k < ISSUE; k++) begin
            if (rst_n && issue_valid[k] && issue_ready[k]) begin
                total++;
                if (sbq[k].size() == 0) begin
                    bad++;
                    $display("FAIL issue_unexpected port=%0d got rob=%0d need none",
                             k, issue_rob[k]);
                end else begin
                    mon_e = sbq[k].pop_front();
                    if ({issue_ps1[k], issue_ps2[k], issue_rob[k], issue_payload[k]}
                        !== mon_e) begin
                        bad++;
                        $display("FAIL issue_order port=%0d got ps1=%0d ps2=%0d rob=%0d need ps1=%0d ps2=%0d rob=%0d",
                                 k, issue_ps1[k], issue_ps2[k], issue_rob[k],
                                 mon_e.ps1, mon_e.ps2, mon_e.rob);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        dispatch_valid = '0;
        cdb_valid = '0;
        flush = 1'b0;
    endtask

    task automatic lane(input int l, input logic [5:0] p1, input logic r1,
                        input logic [5:0] p2, input logic r2,
                        input logic f, input logic [4:0] rob);
        dispatch_valid[l] = 1'b1;
        disp_ps1[l] = p1;
        disp_rdy1[l] = r1;
        disp_ps2[l] = p2;
        disp_rdy2[l] = r2;
        disp_fu[l] = f;
        disp_rob[l] = rob;
        disp_payload[l] = pl_of(rob);
    endtask

    task automatic push(input int port, input logic [5:0] p1,
                        input logic [5:0] p2, input logic [4:0] rob);
        exp_t e;
        e.ps1 = p1;
        e.ps2 = p2;
        e.rob = rob;
        e.pl = pl_of(rob);
        sbq[port].push_back(e);
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (free_count !== 5'd16) begin
            bad++;
            $display("FAIL reset_free got=%0d need=16", free_count);
        end
        total++;
        if (dispatch_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%0b need=1", dispatch_ready);
        end
        total++;
        if (issue_valid !== 2'b00) begin
            bad++;
            $display("FAIL reset_issue_valid got=%b need=00", issue_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_issue();
        cyc();
        lane(0, 6'd5, 1'b1, 6'd6, 1'b1, FU_ALU, 5'd1);
        push(0, 6'd5, 6'd6, 5'd1);
        #1;
        total++;
        if (issue_valid !== 2'b00) begin
            bad++;
            $display("FAIL basic_no_early got=%b need=00", issue_valid);
        end
        cyc();
        #1;
        total++;
        if (issue_valid[0] !== 1'b1 || issue_ps1[0] !== 6'd5) begin
            bad++;
            $display("FAIL basic_present got v=%b ps1=%0d need v=1 ps1=5",
                     issue_valid[0], issue_ps1[0]);
        end
        total++;
        if (free_count !== 5'd15) begin
            bad++;
            $display("FAIL basic_free15 got=%0d need=15", free_count);
        end
        cyc();
        #1;
        total++;
        if (free_count !== 5'd16) begin
            bad++;
            $display("FAIL basic_free16 got=%0d need=16", free_count);
        end
    endtask

    task automatic test_wakeup();
        cyc();
        lane(0, 6'd9, 1'b0, 6'd0, 1'b0, FU_MUL, 5'd2);
        cyc();
        #1;
        total++;
        if (issue_valid[1] !== 1'b0) begin
            bad++;
            $display("FAIL wake_waiting got=%b need=0", issue_valid[1]);
        end
        cyc();
        cdb_valid[0] = 1'b1;
        cdb_preg[0] = 6'd9;
        push(1, 6'd9, 6'd0, 5'd2);
        #1;
        total++;
        if (issue_valid[1] !== 1'b0) begin
            bad++;
            $display("FAIL wake_not_before got=%b need=0", issue_valid[1]);
        end
        cyc();
        #1;
        total++;
        if (issue_valid[1] !== 1'b1 || issue_ps1[1] !== 6'd9) begin
            bad++;
            $display("FAIL wake_present got v=%b ps1=%0d need v=1 ps1=9",
                     issue_valid[1], issue_ps1[1]);
        end
        cyc();
        #1;
        total++;
        if (free_count !== 5'd16) begin
            bad++;
            $display("FAIL wake_free got=%0d need=16", free_count);
        end
    endtask

    task automatic test_bypass();
        cyc();
        lane(0, 6'd12, 1'b0, 6'd7, 1'b1, FU_ALU, 5'd3);
        cdb_valid = 2'b10;
        cdb_preg[0] = 6'd13;
        cdb_preg[1] = 6'd12;
        push(0, 6'd12, 6'd7, 5'd3);
        cyc();
        #1;
        total++;
        if (issue_valid[0] !== 1'b1 || issue_ps1[0] !== 6'd12) begin
            bad++;
            $display("FAIL bypass_present got v=%b ps1=%0d need v=1 ps1=12",
                     issue_valid[0], issue_ps1[0]);
        end
        cyc();
        #1;
        total++;
        if (free_count !== 5'd16) begin
            bad++;
            $display("FAIL bypass_free got=%0d need=16", free_count);
        end
    endtask

    task automatic test_full();
        for (int g = 0; g < 7; g++) begin
            cyc();
            lane(0, 6'(20 + 2 * g), 1'b0, 6'd0, 1'b0, FU_ALU, 5'(2 * g));
            lane(1, 6'(21 + 2 * g), 1'b0, 6'd0, 1'b0, FU_ALU, 5'(2 * g + 1));
        end
        cyc();
        lane(0, 6'd34, 1'b0, 6'd0, 1'b0, FU_ALU, 5'd14);
        cyc();
        #1;
        total++;
        if (free_count !== 5'd1 || dispatch_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_state got free=%0d rdy=%b need free=1 rdy=0",
                     free_count, dispatch_ready);
        end
        lane(0, 6'd60, 1'b1, 6'd0, 1'b0, FU_ALU, 5'd20);
        cyc();
        #1;
        total++;
        if (free_count !== 5'd1) begin
            bad++;
            $display("FAIL full_blocked got=%0d need=1", free_count);
        end
        cdb_valid[1] = 1'b1;
        cdb_preg[1] = 6'd24;
        push(0, 6'd24, 6'd0, 5'd4);
        cyc();
        #1;
        total++;
        if (dispatch_ready !== 1'b0 || issue_valid[0] !== 1'b1) begin
            bad++;
            $display("FAIL full_still got rdy=%b v=%b need rdy=0 v=1",
                     dispatch_ready, issue_valid[0]);
        end
        cyc();
        #1;
        total++;
        if (dispatch_ready !== 1'b1 || free_count !== 5'd2) begin
            bad++;
            $display("FAIL full_freed got rdy=%b free=%0d need rdy=1 free=2",
                     dispatch_ready, free_count);
        end
        flush = 1'b1;
        cyc();
        #1;
        total++;
        if (free_count !== 5'd16) begin
            bad++;
            $display("FAIL full_flush got=%0d need=16", free_count);
        end
    endtask

    task automatic test_age_order();
        issue_ready = 2'b00;
        cyc();
        lane(0, 6'd41, 1'b1, 6'd0, 1'b0, FU_MUL, 5'd11);
        lane(1, 6'd42, 1'b0, 6'd0, 1'b0, FU_ALU, 5'd12);
        push(1, 6'd41, 6'd0, 5'd11);
        cyc();
        lane(0, 6'd30, 1'b1, 6'd31, 1'b1, FU_ALU, 5'd13);
        push(0, 6'd30, 6'd31, 5'd13);
        issue_ready[1] = 1'b1;
        cyc();
        lane(0, 6'd32, 1'b1, 6'd33, 1'b1, FU_ALU, 5'd14);
        lane(1, 6'd34, 1'b1, 6'd35, 1'b1, FU_ALU, 5'd15);
        push(0, 6'd32, 6'd33, 5'd14);
        push(0, 6'd34, 6'd35, 5'd15);
        for (int c = 0; c < 3; c++) begin
            if (c > 0) cyc();
            #1;
            total++;
            if (issue_valid[0] !== 1'b1 || issue_rob[0] !== 5'd13) begin
                bad++;
                $display("FAIL age_hold%0d got v=%b rob=%0d need v=1 rob=13",
                         c, issue_valid[0], issue_rob[0]);
            end
        end
        issue_ready[0] = 1'b1;
        cyc();
        cyc();
        cyc();
        cdb_valid[0] = 1'b1;
        cdb_preg[0] = 6'd42;
        push(0, 6'd42, 6'd0, 5'd12);
        cyc();
        cyc();
        #1;
        total++;
        if (free_count !== 5'd16) begin
            bad++;
            $display("FAIL age_drain got=%0d need=16", free_count);
        end
    endtask

    task automatic test_flush();
        issue_ready = 2'b00;
        for (int g = 0; g < 4; g++) begin
            cyc();
            lane(0, 6'(50 + 2 * g), (g == 0), 6'd0, 1'b0, FU_ALU, 5'(16 + 2 * g));
            lane(1, 6'(51 + 2 * g), 1'b0, 6'd0, 1'b0, FU_ALU, 5'(17 + 2 * g));
        end
        cyc();
        #1;
        total++;
        if (free_count !== 5'd8) begin
            bad++;
            $display("FAIL flush_resident got=%0d need=8", free_count);
        end
        flush = 1'b1;
        issue_ready = 2'b11;
        lane(0, 6'd60, 1'b1, 6'd61, 1'b1, FU_ALU, 5'd24);
        lane(1, 6'd62, 1'b1, 6'd63, 1'b1, FU_MUL, 5'd25);
        #1;
        total++;
        if (issue_valid !== 2'b00) begin
            bad++;
            $display("FAIL flush_noissue got=%b need=00", issue_valid);
        end
        cyc();
        #1;
        total++;
        if (free_count !== 5'd16 || issue_valid !== 2'b00) begin
            bad++;
            $display("FAIL flush_empty got free=%0d v=%b need free=16 v=00",
                     free_count, issue_valid);
        end
    endtask

    task automatic test_async_reset();
        issue_ready = 2'b00;
        cyc();
        lane(0, 6'd3, 1'b1, 6'd4, 1'b1, FU_ALU, 5'd26);
        lane(1, 6'd5, 1'b0, 6'd0, 1'b0, FU_MUL, 5'd27);
        cyc();
        #1;
        total++;
        if (issue_valid !== 2'b01 || free_count !== 5'd14) begin
            bad++;
            $display("FAIL arst_pre got v=%b free=%0d need v=01 free=14",
                     issue_valid, free_count);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (free_count !== 5'd16 || dispatch_ready !== 1'b1 || issue_valid !== 2'b00) begin
            bad++;
            $display("FAIL arst_now got free=%0d rdy=%b v=%b need free=16 rdy=1 v=00",
                     free_count, dispatch_ready, issue_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue_ready = 2'b11;
        cyc();
        cyc();
        #1;
        total++;
        if (free_count !== 5'd16 || issue_valid !== 2'b00) begin
            bad++;
            $display("FAIL arst_after got free=%0d v=%b need free=16 v=00",
                     free_count, issue_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        dispatch_valid = '0;
        disp_ps1 = '0;
        disp_ps2 = '0;
        disp_rdy1 = '0;
        disp_rdy2 = '0;
        disp_fu = '0;
        disp_rob = '0;
        disp_payload = '0;
        cdb_valid = '0;
        cdb_preg = '0;
        issue_ready = 2'b11;

        test_reset();
        test_basic_issue();
        test_wakeup();
        test_bypass();
        test_full();
        test_age_order();
        test_flush();
        test_async_reset();

        total++;
        if (sbq[0].size() + sbq[1].size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drained got=%0d pending need=0",
                     sbq[0].size() + sbq[1].size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
